filt_result_writer: RTL and testbench
=====================================

FILT_RESULT_WRITER -- requirements
Module: filt_result_writer

Interface
REQ-001 Parameter IMG_W, default 512, frame line pitch in words.
REQ-002 Parameter BASE_ADDR, default 262144, SRAM word address of output frame pixel (0,0).
REQ-003 Parameter MAX_VAL, default 255, clamp ceiling for written pixels.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse arming a new frame.
REQ-007 in_en  input  1  filtered-pixel valid strobe from the 3x3 filter.
REQ-008 in_data  input  20  filtered-pixel value, unsigned.
REQ-009 mem_csn  output  1  SRAM chip select, active-low.
REQ-010 mem_wen  output  1  SRAM write enable, active-high (1 = write).
REQ-011 mem_a  output  19  SRAM word address.
REQ-012 mem_din  output  16  SRAM write data.
REQ-013 busy  output  1  high in STREAM and BORDER.
REQ-014 frame_done  output  1  one-cycle pulse at frame completion.
REQ-015 ovf_cnt  output  16  count of clamped samples in current frame.
REQ-016 err  output  1  sticky: in_en seen while not in STREAM.

Function
REQ-017 FSM states IDLE, STREAM, BORDER, DONE; reset state IDLE.
REQ-018 IDLE: start=1 -> STREAM next cycle; x<=1, y<=1, ovf_cnt<=0, err<=0.
REQ-019 STREAM: each cycle with in_en=1 accepts one pixel for interior position (x,y), x,y in 1..IMG_W-2, raster order.
REQ-020 Accepted pixel written exactly 1 cycle later: mem_wen=1, mem_a=BASE_ADDR+y*IMG_W+x, mem_din=clamp(in_data).
REQ-021 clamp: in_data>MAX_VAL -> MAX_VAL and ovf_cnt+1 (saturating at 65535); else in_data[15:0].
REQ-022 Position advance: x=IMG_W-2 -> x<=1, y<=y+1; else x<=x+1; no advance on in_en=0 cycles.
REQ-023 Acceptance of (IMG_W-2,IMG_W-2) -> BORDER next cycle; that final write still issues on the first BORDER cycle.
REQ-024 BORDER: one zero write per cycle, mem_wen=1, mem_din=0; order row 0 x=0..IMG_W-1, row IMG_W-1 x=0..IMG_W-1, column 0 y=1..IMG_W-2, column IMG_W-1 y=1..IMG_W-2; 4*IMG_W-4 writes (2044 default).
REQ-025 After last border write -> DONE; DONE asserts frame_done for one cycle, then IDLE.
REQ-026 mem_csn=0 whenever busy=1 or a write is pending; otherwise 1; mem_wen=0 on all non-write cycles.
REQ-027 in_en=1 outside STREAM: sample dropped, no write, err<=1 held until next accepted start.
REQ-028 start while busy or in DONE ignored, no effect on position or counters.
REQ-029 mem_a arithmetic at full 19-bit width; BASE_ADDR+(IMG_W*IMG_W-1) shall not exceed 2^19-1 (default max 524287).
REQ-030 Back-to-back in_en every cycle supported with no stall; throughput 1 pixel/cycle.

Reset
REQ-031 rst=1: state IDLE, x=1, y=1, mem_csn=1, mem_wen=0, mem_a=0, mem_din=0, busy=0, frame_done=0, ovf_cnt=0, err=0.
REQ-032 rst mid-frame aborts immediately; no write issued in the cycle rst deasserts or thereafter until a new start.

Verification
REQ-033 start, then in_en with in_data=0x00042 for first pixel -> next cycle mem_wen=1, mem_a=262657, mem_din=0x0042.
REQ-034 in_data=0x00300 -> mem_din=0x00FF, ovf_cnt increments 0->1.
REQ-035 Stream 510 pixels -> 511th pixel written at mem_a=BASE_ADDR+2*512+1=263169.
REQ-036 Full frame 260100 pixels, in_en continuous -> 2044 zero writes (first at 262144, last at 524287 region column 511 row 510 = 523775), then single frame_done pulse, busy=0.
REQ-037 in_en=1 in IDLE -> no write, err=1; next start clears err.
REQ-038 rst asserted after 1000 pixels -> mem_wen=0, mem_csn=1, busy=0 immediately; fresh start restarts at (1,1).

Source files
------------

// File: rtl/filt_result_writer.sv
// Writes one frame of 3x3-filtered pixels to SRAM: interior pixels are clamped and written as they
// arrive, then the one-pixel frame border is zero-filled, and frame_done pulses once at the end.
module filt_result_writer #(
  parameter int IMG_W     = 512,
  parameter int BASE_ADDR = 262144,
  parameter int MAX_VAL   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_en,
  input  logic [19:0] in_data,
  output logic        mem_csn,
  output logic        mem_wen,
  output logic [18:0] mem_a,
  output logic [15:0] mem_din,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] ovf_cnt,
  output logic        err
);

  // state  | meaning
  // IDLE   | waiting for start
  // STREAM | accepting interior pixels in raster order
  // BORDER | issuing one zero write per cycle around the frame edge
  // DONE   | frame_done pulse, then back to IDLE
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_BORDER = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int CW = $clog2(IMG_W);
  localparam int NB = 4 * IMG_W - 4;
  localparam int BW = $clog2(NB);

  localparam logic [CW-1:0] XY_FIRST = CW'(1);
  localparam logic [CW-1:0] XY_LAST  = CW'(IMG_W - 2);
  localparam logic [CW-1:0] XY_EDGE  = CW'(IMG_W - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(NB - 1);
  localparam logic [19:0]   MAX_IN   = 20'(MAX_VAL);
  localparam logic [15:0]   MAX_OUT  = 16'(MAX_VAL);

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [BW-1:0] b_q, b_d;
  logic          wen_q, wen_d;
  logic [18:0]   a_q, a_d;
  logic [15:0]   din_q, din_d;
  logic [15:0]   ovf_q, ovf_d;
  logic          err_q, err_d;

  logic          accept;
  logic          arm;
  logic          clamp_hit;
  logic          last_pix;
  logic [CW-1:0] bx;
  logic [CW-1:0] by;

  function automatic logic [18:0] pix_addr(input logic [CW-1:0] px, input logic [CW-1:0] py);
    return 19'(BASE_ADDR) + 19'(py) * 19'(IMG_W) + 19'(px);
  endfunction

  assign accept    = (state_q == S_STREAM) && in_en;
  assign arm       = (state_q == S_IDLE) && start;
  assign clamp_hit = in_data > MAX_IN;
  assign last_pix  = (x_q == XY_LAST) && (y_q == XY_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= XY_FIRST;
      y_q     <= XY_FIRST;
      b_q     <= '0;
      wen_q   <= 1'b0;
      a_q     <= '0;
      din_q   <= '0;
      ovf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      b_q     <= b_d;
      wen_q   <= wen_d;
      a_q     <= a_d;
      din_q   <= din_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_STREAM;
      S_STREAM: if (in_en && last_pix) state_d = S_BORDER;
      S_BORDER: if (b_q == B_LAST) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Border walk: row 0, row IMG_W-1, then column 0 and column IMG_W-1 without the corners.
  always_comb begin
    bx = '0;
    by = '0;
    if (b_q < BW'(IMG_W)) begin
      bx = CW'(b_q);
    end else if (b_q < BW'(2 * IMG_W)) begin
      bx = CW'(b_q - BW'(IMG_W));
      by = XY_EDGE;
    end else if (b_q < BW'(3 * IMG_W - 2)) begin
      by = CW'(b_q - BW'(2 * IMG_W - 1));
    end else begin
      bx = XY_EDGE;
      by = CW'(b_q - BW'(3 * IMG_W - 3));
    end
  end

  // Datapath: every write is registered, so it appears on the cycle after it is decided.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    b_d   = b_q;
    wen_d = 1'b0;
    a_d   = a_q;
    din_d = din_q;
    ovf_d = ovf_q;
    err_d = err_q;

    if (arm) begin
      x_d   = XY_FIRST;
      y_d   = XY_FIRST;
      b_d   = '0;
      ovf_d = '0;
      err_d = 1'b0;
    end

    if (in_en && (state_q != S_STREAM)) begin
      err_d = 1'b1;
    end

    if (accept) begin
      wen_d = 1'b1;
      a_d   = pix_addr(x_q, y_q);
      din_d = clamp_hit ? MAX_OUT : in_data[15:0];
      if (clamp_hit && (ovf_q != 16'hFFFF)) begin
        ovf_d = ovf_q + 16'd1;
      end
      if (x_q == XY_LAST) begin
        x_d = XY_FIRST;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    if (state_q == S_BORDER) begin
      wen_d = 1'b1;
      a_d   = pix_addr(bx, by);
      din_d = '0;
      b_d   = b_q + 1'b1;
    end
  end

  // Outputs; the chip select also covers the final write that lands in DONE.
  always_comb begin
    busy       = (state_q == S_STREAM) || (state_q == S_BORDER);
    frame_done = (state_q == S_DONE);
    mem_csn    = ~(busy | wen_q);
  end

  assign mem_wen = wen_q;
  assign mem_a   = a_q;
  assign mem_din = din_q;
  assign ovf_cnt = ovf_q;
  assign err     = err_q;

endmodule

// File: tb/tb_filt_result_writer.sv
// Randomized bench for filt_result_writer on a small 32x32 frame placed at the top of the address
// space; a transaction-level model predicts every output each cycle, plus hand-computed pins.
module tb_filt_result_writer;

  localparam int W    = 32;
  localparam int BASE = 523264;
  localparam int MAXV = 255;
  localparam int NPIX = (W - 2) * (W - 2);
  localparam int NB   = 4 * W - 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_en;
  logic [19:0] in_data;
  logic        mem_csn;
  logic        mem_wen;
  logic [18:0] mem_a;
  logic [15:0] mem_din;
  logic        busy;
  logic        frame_done;
  logic [15:0] ovf_cnt;
  logic        err;

  filt_result_writer #(.IMG_W(W), .BASE_ADDR(BASE), .MAX_VAL(MAXV)) dut (
    .clk(clk), .rst(rst), .start(start), .in_en(in_en), .in_data(in_data),
    .mem_csn(mem_csn), .mem_wen(mem_wen), .mem_a(mem_a), .mem_din(mem_din),
    .busy(busy), .frame_done(frame_done), .ovf_cnt(ovf_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
  endtask

  // Border address list built straight from the frame geometry.
  int border_a[NB];
  initial begin
    int k;
    k = 0;
    for (int x = 0; x < W; x++) begin border_a[k] = BASE + x; k++; end
    for (int x = 0; x < W; x++) begin border_a[k] = BASE + (W - 1) * W + x; k++; end
    for (int y = 1; y < W - 1; y++) begin border_a[k] = BASE + y * W; k++; end
    for (int y = 1; y < W - 1; y++) begin border_a[k] = BASE + y * W + W - 1; k++; end
  end

  // Model: expected outputs for the cycle following each rising edge.
  bit m_stream = 0, m_border = 0;
  int m_n = 0, m_bi = 0;
  bit e_wen = 0, e_done = 0, e_err = 0;
  int e_a = 0, e_din = 0, e_ovf = 0;

  always @(posedge clk) begin
    bit was_done;
    int px, py;
    if (rst) begin
      m_stream = 0; m_border = 0; m_n = 0; m_bi = 0;
      e_wen = 0; e_done = 0; e_err = 0; e_a = 0; e_din = 0; e_ovf = 0;
    end else begin
      was_done = e_done;
      e_wen = 0;
      e_done = 0;
      if (m_stream) begin
        if (in_en) begin
          px = m_n % (W - 2) + 1;
          py = m_n / (W - 2) + 1;
          e_wen = 1;
          e_a = BASE + py * W + px;
          if (in_data > MAXV) begin
            e_din = MAXV;
            if (e_ovf < 65535) e_ovf++;
          end else begin
            e_din = int'(in_data[15:0]);
          end
          m_n++;
          if (m_n == NPIX) begin m_stream = 0; m_border = 1; m_bi = 0; end
        end
      end else begin
        if (m_border) begin
          e_wen = 1; e_a = border_a[m_bi]; e_din = 0; m_bi++;
          if (m_bi == NB) begin m_border = 0; e_done = 1; end
        end else if (!was_done && start) begin
          m_stream = 1; m_n = 0; e_ovf = 0; e_err = 0;
        end
        if (in_en) e_err = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("mem_wen", 32'(mem_wen), 32'(e_wen));
    if (e_wen) begin
      chk("mem_a", 32'(mem_a), e_a);
      chk("mem_din", 32'(mem_din), e_din);
    end
    chk("busy", 32'(busy), 32'(m_stream || m_border));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("mem_csn", 32'(mem_csn), 32'(!(m_stream || m_border || e_wen)));
    chk("ovf_cnt", 32'(ovf_cnt), e_ovf);
    chk("err", 32'(err), 32'(e_err));
    if (rst) begin
      chk("rst_mem_a", 32'(mem_a), 0);
      chk("rst_mem_din", 32'(mem_din), 0);
    end
  end

  function automatic logic [19:0] rnd_data();
    logic [19:0] v;
    case ($urandom_range(0, 3))
      0:       v = 20'($urandom);
      1:       v = 20'(MAXV);
      2:       v = 20'(MAXV + 1);
      default: v = 20'($urandom_range(0, MAXV));
    endcase
    if (v == 20'd0) v = 20'd1;
    return v;
  endfunction

  // Inputs change on the falling edge; returns at the next falling edge with outputs settled.
  task automatic step(input logic s, input logic e, input logic [19:0] d);
    start = s; in_en = e; in_data = d;
    @(negedge clk);
  endtask

  task automatic run_pixels(input int p_en, input int p_start);
    int guard;
    guard = 0;
    while (m_stream && guard < 20000) begin
      step($urandom_range(0, 99) < p_start, $urandom_range(0, 99) < p_en, rnd_data());
      guard++;
    end
    start = 0; in_en = 0;
    chk("stream_finished", 32'(m_stream), 0);
  endtask

  task automatic run_border(input int p_en, output int zw, output int first_a,
                            output int last_a, output int dn);
    zw = 0; first_a = -1; last_a = -1; dn = 0;
    for (int i = 0; i < NB + 8; i++) begin
      if (mem_wen && mem_din == 16'd0) begin
        if (zw == 0) first_a = int'(mem_a);
        last_a = int'(mem_a);
        zw++;
      end
      if (frame_done) dn++;
      step(frame_done, $urandom_range(0, 99) < p_en, rnd_data());
    end
    start = 0; in_en = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int zw, fa, la, dn;
    rst = 1; start = 0; in_en = 0; in_data = 0;
    repeat (3) @(negedge clk);
    chk("reset_csn", 32'(mem_csn), 1);
    chk("reset_busy", 32'(busy), 0);
    #2 rst = 0;

    // Sample outside STREAM is dropped and flags err until the next start.
    step(0, 1, 20'd5);
    chk("idle_err", 32'(err), 1);
    chk("idle_no_write", 32'(mem_wen), 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("start_clears_err", 32'(err), 0);
    chk("start_busy", 32'(busy), 1);

    // Frame 1: directed start, then mostly continuous.
    step(0, 1, 20'h00042);
    chk("first_wen", 32'(mem_wen), 1);
    chk("first_addr", 32'(mem_a), 523297);
    chk("first_din", 32'(mem_din), 32'h42);
    chk("first_ovf", 32'(ovf_cnt), 0);
    step(0, 1, 20'h00300);
    chk("clamp_din", 32'(mem_din), 32'hFF);
    chk("clamp_ovf", 32'(ovf_cnt), 1);
    chk("second_addr", 32'(mem_a), 523298);
    for (int i = 0; i < 28; i++) step(i == 10, 1, rnd_data());
    step(0, 1, 20'h00007);
    chk("row2_addr", 32'(mem_a), 523329);
    chk("row2_din", 32'(mem_din), 7);
    run_pixels(100, 2);
    run_border(0, zw, fa, la, dn);
    chk("border_count", zw, NB);
    chk("border_first", fa, 523264);
    chk("border_last", la, 524255);
    chk("done_pulses", dn, 1);
    chk("idle_after_frame", 32'(busy), 0);

    // Frame 2: gappy input, stray starts, stray samples during border.
    step(1, 0, 0);
    run_pixels(60, 5);
    run_border(10, zw, fa, la, dn);
    chk("f2_done_pulses", dn, 1);

    // Mid-frame reset aborts at once; a fresh start begins again at (1,1).
    step(1, 0, 0);
    for (int i = 0; i < 400; i++) step(0, 1, rnd_data());
    start = 0; in_en = 0;
    #2 rst = 1;
    #1;
    chk("abort_wen", 32'(mem_wen), 0);
    chk("abort_csn", 32'(mem_csn), 1);
    chk("abort_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 20'h00010);
    chk("restart_addr", 32'(mem_a), 523297);
    chk("restart_ovf", 32'(ovf_cnt), 0);
    run_pixels(85, 3);
    run_border(0, zw, fa, la, dn);
    chk("f3_border_count", zw, NB);
    chk("f3_done_pulses", dn, 1);

    repeat (3) step(0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
